// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and status flag positions for alu_mc.
package alu_pkg;

    // Opcodes on the 5-bit command bus
    localparam logic [4:0] OP_MOV = 5'b00001;
    localparam logic [4:0] OP_MVN = 5'b01001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_ADC = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SBC = 5'b00101;
    localparam logic [4:0] OP_AND = 5'b00110;
    localparam logic [4:0] OP_ORR = 5'b00111;
    localparam logic [4:0] OP_EOR = 5'b01000;
    localparam logic [4:0] OP_LSL = 5'b10000;
    localparam logic [4:0] OP_LSR = 5'b10001;
    localparam logic [4:0] OP_ASR = 5'b10010;
    localparam logic [4:0] OP_ROR = 5'b10011;
    localparam logic [4:0] OP_MUL = 5'b10100;

    // Shifter sub-op: low two bits of the shift opcodes
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Controller state
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bit positions inside status {N,Z,C,V}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: LSL/LSR/ASR/ROR with shifter carry-out.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [7:0]   amt,
    input  logic [1:0]   op,
    input  logic         c_in,
    output logic [N-1:0] res_c,
    output logic         carry_c
);

    localparam int unsigned LW = $clog2(N);
    localparam logic [LW:0] N_W = (LW+1)'(N);

    logic [N:0]    lsl_w;
    logic [N:0]    lsr_w;
    logic [N:0]    asr_w;
    logic [N-1:0]  ror_w;
    logic [LW-1:0] rot;
    logic [LW:0]   rot_inv;

    // One extra bit below/above the operand catches the last bit shifted out
    always_comb begin
        lsl_w   = {1'b0, a} << amt;
        lsr_w   = {a, 1'b0} >> amt;
        asr_w   = $signed({a, 1'b0}) >>> amt;
        rot     = amt[LW-1:0];
        rot_inv = N_W - {1'b0, rot};
        ror_w   = (a >> rot) | (a << rot_inv);
    end

    // Select the result; a zero amount passes the operand and carry through
    always_comb begin
        res_c   = a;
        carry_c = c_in;
        if (amt != 8'd0) begin
            case (op)
                SH_LSL: begin
                    res_c   = lsl_w[N-1:0];
                    carry_c = lsl_w[N];
                end
                SH_LSR: begin
                    res_c   = lsr_w[N:1];
                    carry_c = lsr_w[0];
                end
                SH_ASR: begin
                    if (32'(amt) >= N) begin
                        res_c   = {N{a[N-1]}};
                        carry_c = a[N-1];
                    end else begin
                        res_c   = asr_w[N:1];
                        carry_c = asr_w[0];
                    end
                end
                default: begin
                    res_c   = ror_w;
                    carry_c = ror_w[N-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply,
// valid/ready handshakes on both sides and a registered {N,Z,C,V} status.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned MUL_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] input_a,
    input  logic [N-1:0] input_b,
    input  logic         carry_in,
    input  logic [4:0]   command,
    input  logic         set_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   status_out
);

    localparam int unsigned CW        = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    state_t        state_q,     state_d;
    logic [N-1:0]  result_q,    result_d;
    logic [3:0]    status_q,    status_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  mcand_q,     mcand_d;
    logic [N-1:0]  mplier_q,    mplier_d;
    logic [N-1:0]  acc_q,       acc_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          setf_q,      setf_d;

    logic          accept;
    logic          is_mul;
    logic          add_cin;
    logic          sub_bin;
    logic [N:0]    add_w;
    logic [N:0]    sub_w;
    logic          v_add;
    logic          v_sub;
    logic [N-1:0]  sh_res;
    logic          sh_carry;
    logic [N-1:0]  alu_res;
    logic          alu_c;
    logic          alu_v;
    logic [N-1:0]  mul_sum;

    assign in_ready   = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept     = in_valid & in_ready;
    assign is_mul     = (MUL_EN != 0) && (command == OP_MUL);
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign status_out = status_q;

    alu_shifter #(.N(N)) u_shifter (
        .a       (input_a),
        .amt     (input_b[7:0]),
        .op      (command[1:0]),
        .c_in    (status_q[FLAG_C]),
        .res_c   (sh_res),
        .carry_c (sh_carry)
    );

    // (N+1)-bit add/subtract; bit N is the C flag in both directions
    always_comb begin
        add_cin = (command == OP_ADC) & carry_in;
        sub_bin = (command == OP_SBC) & ~carry_in;
        add_w   = {1'b0, input_a} + {1'b0, input_b} + (N+1)'(add_cin);
        sub_w   = {1'b0, input_a} - {1'b0, input_b} - (N+1)'(sub_bin);
        v_add   = (input_a[N-1] == input_b[N-1]) & (add_w[N-1] != input_a[N-1]);
        v_sub   = (input_a[N-1] != input_b[N-1]) & (sub_w[N-1] != input_a[N-1]);
    end

    // Single-cycle result and the C/V each opcode produces (others keep current flags)
    always_comb begin
        alu_res = '0;
        alu_c   = status_q[FLAG_C];
        alu_v   = status_q[FLAG_V];
        case (command)
            OP_MOV: alu_res = input_a;
            OP_MVN: alu_res = ~input_a;
            OP_ADD, OP_ADC: begin
                alu_res = add_w[N-1:0];
                alu_c   = add_w[N];
                alu_v   = v_add;
            end
            OP_SUB, OP_SBC: begin
                alu_res = sub_w[N-1:0];
                alu_c   = sub_w[N];
                alu_v   = v_sub;
            end
            OP_AND: alu_res = input_a & input_b;
            OP_ORR: alu_res = input_a | input_b;
            OP_EOR: alu_res = input_a ^ input_b;
            OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
                alu_res = sh_res;
                alu_c   = sh_carry;
            end
            default: alu_res = '0;
        endcase
    end

    // One shift-add multiply step
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state and datapath updates for IDLE / MUL / DONE
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        status_d    = status_q;
        out_valid_d = out_valid_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        setf_d      = setf_q;

        case (state_q)
            ST_IDLE: ;
            ST_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d     = ST_DONE;
                    result_d    = mul_sum;
                    out_valid_d = 1'b1;
                    if (setf_q) begin
                        status_d[FLAG_N] = mul_sum[N-1];
                        status_d[FLAG_Z] = (mul_sum == '0);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // A newly accepted operation overrides the retire path above
        if (accept) begin
            if (is_mul) begin
                state_d     = ST_MUL;
                out_valid_d = 1'b0;
                mcand_d     = input_a;
                mplier_d    = input_b;
                acc_d       = '0;
                cnt_d       = '0;
                setf_d      = set_flags;
            end else begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                result_d    = alu_res;
                if (set_flags) begin
                    status_d[FLAG_N] = alu_res[N-1];
                    status_d[FLAG_Z] = (alu_res == '0);
                    status_d[FLAG_C] = alu_c;
                    status_d[FLAG_V] = alu_v;
                end
            end
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            status_q    <= '0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            setf_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            setf_q      <= setf_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (N=32): directed corner cases plus randomized traffic.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        carry_in;
    logic [4:0]  command;
    logic        set_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  status_out;

    always #5 clk = ~clk;

    alu_mc #(.N(32), .MUL_EN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .input_a    (input_a),
        .input_b    (input_b),
        .carry_in   (carry_in),
        .command    (command),
        .set_flags  (set_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .status_out (status_out)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  st;
        logic [4:0]  op;
        int          acc_edge;
        int          delay;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [3:0]  model_st = 4'b0000;
    bit          rand_bp  = 1'b0;
    bit          bp_hold  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: result and {N,Z,C,V} from the arithmetic definition of each opcode
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic [3:0] st,
                                  output logic [31:0] r, output logic [3:0] nst);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint unsigned w;
        logic c = st[1];
        logic v = st[0];
        int amt = int'(b[7:0]);
        int rr;
        r = 32'h0;
        case (op)
            5'b00001: r = a;
            5'b01001: r = ~a;
            5'b00010, 5'b00011: begin
                w = ua + ub + ((op == 5'b00011 && cin) ? 64'd1 : 64'd0);
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5'b00100, 5'b00101: begin
                w = ua - ub - ((op == 5'b00101 && !cin) ? 64'd1 : 64'd0);
                r = w[31:0];
                c = w[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            5'b00110: r = a & b;
            5'b00111: r = a | b;
            5'b01000: r = a ^ b;
            5'b10000: begin
                if (amt == 0) r = a;
                else if (amt <= 32) begin
                    w = ua << amt;
                    r = w[31:0];
                    c = w[32];
                end else begin
                    r = 32'h0;
                    c = 1'b0;
                end
            end
            5'b10001: begin
                if (amt == 0) r = a;
                else if (amt <= 32) begin
                    r = (amt == 32) ? 32'h0 : (a >> amt);
                    c = a[amt-1];
                end else begin
                    r = 32'h0;
                    c = 1'b0;
                end
            end
            5'b10010: begin
                if (amt == 0) r = a;
                else if (amt >= 32) begin
                    r = {32{a[31]}};
                    c = a[31];
                end else begin
                    r = $signed(a) >>> amt;
                    c = a[amt-1];
                end
            end
            5'b10011: begin
                rr = amt % 32;
                r  = (rr == 0) ? a : ((a >> rr) | (a << (32 - rr)));
                if (amt != 0) c = r[31];
            end
            5'b10100: begin
                w = ua * ub;
                r = w[31:0];
            end
            default: r = 32'h0;
        endcase
        nst = {r[31], (r == 32'h0), c, v};
    endfunction

    // Output side backpressure, changed just after each rising edge
    always @(posedge clk) begin
        #2;
        if (bp_hold)      out_ready = 1'b0;
        else if (rand_bp) out_ready = ($urandom_range(3) != 0);
        else              out_ready = 1'b1;
    end

    // Monitor: pops the scoreboard on each new result and checks holding while stalled
    logic        presented = 1'b0;
    logic [31:0] held_r;
    logic [3:0]  held_s;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            presented = 1'b0;
        end else if (out_valid) begin
            if (!presented) begin
                presented = 1'b1;
                held_r    = result;
                held_s    = status_out;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: result %0h status %0h, expected no output", result, status_out);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("result_op%02h", e.op), 64'(result), 64'(e.res));
                    chk($sformatf("status_op%02h", e.op), 64'(status_out), 64'(e.st));
                    chk($sformatf("latency_op%02h", e.op), 64'(cyc - e.acc_edge), 64'(e.delay));
                end
            end else begin
                chk("hold_result", 64'(result), 64'(held_r));
                chk("hold_status", 64'(status_out), 64'(held_s));
            end
            if (out_ready) presented = 1'b0;
        end
    end

    // Offer one operation, wait for acceptance and push its expected response
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sf, output int acc_edge);
        exp_t        e;
        int          waitc = 0;
        logic [31:0] r;
        logic [3:0]  ns;
        @(negedge clk);
        in_valid  = 1'b1;
        command   = op;
        input_a   = a;
        input_b   = b;
        carry_in  = cin;
        set_flags = sf;
        #1;
        while (!in_ready) begin
            waitc++;
            if (waitc > 300) begin
                n_checks++;
                $display("FAIL accept_timeout: in_ready %b after %0d cycles, expected 1", in_ready, waitc);
                in_valid = 1'b0;
                acc_edge = -1;
                return;
            end
            @(negedge clk);
            #1;
        end
        model(op, a, b, cin, model_st, r, ns);
        if (sf) model_st = ns;
        e.res      = r;
        e.st       = model_st;
        e.op       = op;
        e.acc_edge = cyc + 1;
        e.delay    = (op == 5'b10100) ? 32 : 0;
        sb_q.push_back(e);
        acc_edge = cyc + 1;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [4:0] op_tab [18] = '{5'b00001, 5'b01001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                                5'b00110, 5'b00111, 5'b01000, 5'b10000, 5'b10001, 5'b10010,
                                5'b10011, 5'b10100, 5'b00000, 5'b01010, 5'b10101, 5'b11111};

    initial begin
        int          ae0, ae1, ae2, ae3;
        logic [4:0]  op;
        logic [31:0] a, b;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        input_a   = '0;
        input_b   = '0;
        carry_in  = 1'b0;
        command   = '0;
        set_flags = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_status", 64'(status_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Signed overflow on ADD
        issue(5'b00010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, ae0);
        idle();
        drain();

        // SUB to zero then ADC with explicit carry
        issue(5'b00100, 32'd5, 32'd5, 1'b0, 1'b1, ae0);
        issue(5'b00011, 32'd0, 32'd0, 1'b1, 1'b1, ae0);
        idle();
        drain();

        // Set C and V, then MUL must keep them while in_ready stays low
        issue(5'b00010, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, ae0);
        issue(5'b10100, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, ae0);
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("mul_in_ready_low", 64'(in_ready), 64'd0);
            chk("mul_no_early_valid", 64'(out_valid), 64'd0);
        end
        drain();

        // Shift corners
        issue(5'b10001, 32'h8000_0001, 32'd1, 1'b0, 1'b1, ae0);
        issue(5'b10000, 32'h8000_0001, 32'd40, 1'b0, 1'b1, ae0);
        issue(5'b10010, 32'h8000_0000, 32'd40, 1'b0, 1'b1, ae0);
        issue(5'b10011, 32'h0000_0001, 32'd33, 1'b0, 1'b1, ae0);
        issue(5'b10000, 32'h1234_5678, 32'd0, 1'b0, 1'b1, ae0);
        idle();
        drain();

        // Backpressure: result must hold while out_ready is low
        bp_hold = 1'b1;
        @(posedge clk);
        issue(5'b00110, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 1'b1, ae0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_out_valid_high", 64'(out_valid), 64'd1);
        end
        bp_hold = 1'b0;
        issue(5'b00110, 32'hFFFF_0000, 32'h1234_5678, 1'b0, 1'b1, ae1);
        issue(5'b00110, 32'h0000_FFFF, 32'h1234_5678, 1'b0, 1'b1, ae2);
        issue(5'b00110, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b1, ae3);
        idle();
        chk("b2b_gap_1", 64'(ae2 - ae1), 64'd1);
        chk("b2b_gap_2", 64'(ae3 - ae2), 64'd1);
        drain();

        // Randomized traffic with random output stalls
        rand_bp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            op = op_tab[$urandom_range(17)];
            a  = rnd_word();
            b  = rnd_word();
            if (op[4] && op[3:2] == 2'b00 && op != 5'b10100) begin
                b[7:0] = ($urandom_range(9) == 0) ? 8'hFF : 8'($urandom_range(40));
            end
            issue(op, a, b, 1'($urandom_range(1)), 1'($urandom_range(3) != 0), ae0);
            if ($urandom_range(4) == 0) idle();
        end
        idle();
        rand_bp = 1'b0;
        drain();

        // Make status non-zero, then reset in the middle of a MUL
        issue(5'b00100, 32'd1, 32'd2, 1'b0, 1'b1, ae0);
        issue(5'b10100, 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b1, ae0);
        idle();
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        model_st = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_status", 64'(status_out), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        repeat (40) @(negedge clk);

        // Normal operation after the abort
        issue(5'b00010, 32'd1, 32'd2, 1'b0, 1'b1, ae0);
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter N, default 32, datapath width (N >= 8, power of two).
REQ-002 The block SHALL have parameter MUL_EN, default 1, which enables the iterative multiply (0 = MUL decodes as default).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  operation accepted when in_valid and in_ready are both high at a clock edge.
REQ-007 input_a, input_b  input  N  operands.
REQ-008 carry_in  input  1  carry for ADC/SBC.
REQ-009 command  input  5  opcode, defined in REQ-013.
REQ-010 set_flags  input  1  update status_out when this operation completes.
REQ-011 out_valid, out_ready  output, input  1  result handshake; the result transfers when both are high.
REQ-012 result  output  N; status_out  output  4  registered {N,Z,C,V}.

Function
REQ-013 Opcodes: 00001 MOV, 01001 MVN, 00010 ADD, 00011 ADC, 00100 SUB, 00101 SBC, 00110 AND, 00111 ORR, 01000 EOR, 10000 LSL, 10001 LSR, 10010 ASR, 10011 ROR, 10100 MUL; every other code SHALL yield result 0.
REQ-014 FSM states: IDLE, MUL, DONE.
- IDLE + accept non-MUL -> DONE.
- IDLE + accept MUL -> MUL.
- MUL after N iterations -> DONE.
- DONE + out_ready -> IDLE, or directly to the next operation if one is accepted on the same edge.
REQ-015 in_ready SHALL equal (state==IDLE) | (state==DONE & out_ready), giving one operation per cycle for non-MUL ops under no backpressure.
REQ-016 Operands and command SHALL be captured on accept; later input changes SHALL NOT affect the operation in flight.
REQ-017 Non-MUL ops SHALL assert out_valid on the edge that accepts them (latency 1).
REQ-018 MUL SHALL assert out_valid exactly N cycles after accept, using one shift-add step per cycle.
REQ-019 result and out_valid SHALL hold stable in DONE until out_ready.
REQ-020 Arithmetic: {C,result} SHALL be the (N+1)-bit sum or difference (ADC adds carry_in; SBC subtracts ~carry_in).
- V for add: operand signs equal and result sign differs.
- V for sub: operand signs differ and result sign differs from input_a.
REQ-021 Shifts: the amount SHALL be input_b[7:0].
- Amount 0: result = input_a, C preserved.
- LSL/LSR amount 1..N: C = last bit shifted out.
- LSL/LSR amount > N: result 0, C = 0.
- ASR amount >= N: all bits = sign, C = sign.
- ROR: rotate by amount mod N; C = result[N-1] when amount != 0.
REQ-022 MUL SHALL return the low N bits of the unsigned product.
REQ-023 MOV, MVN, AND, ORR, EOR, shifts and MUL SHALL preserve V; MOV, MVN, logic ops and MUL SHALL also preserve C.
REQ-024 N = result[N-1] and Z = (result==0); status_out SHALL update on the edge entering DONE, only if the captured set_flags = 1.
REQ-025 Status SHALL be visible to the next accepted operation, so a dependent ADC or SBC uses the updated C when the source supplies it.

Reset
REQ-026 With rst_n low at a clock edge, the block SHALL go to state IDLE, out_valid 0, result 0 and status_out 0000; in_ready SHALL be 1 on the first cycle after rst_n is released.
REQ-027 Reset during MUL or DONE SHALL abort the operation silently; no out_valid SHALL be produced for it.

Structure
REQ-028 Package alu_pkg SHALL hold the opcode constants, the FSM state typedef and the flag bit indices.
REQ-029 Sub-module alu_shifter (combinational, parameter N) SHALL compute the shift result and shifter carry-out.

Verification
REQ-030 ADD 0x7FFFFFFF + 0x00000001 with set_flags=1 -> result 0x80000000, status 1001, out_valid 1 cycle after accept.
REQ-031 SUB 5 - 5 with set_flags=1 -> result 0, status 0100; then ADC 0 + 0 with carry_in=1 -> result 1.
REQ-032 MUL 0x00010000 * 0x00010000 -> result 0, Z=1, C and V unchanged, out_valid exactly 32 cycles after accept, in_ready low throughout.
REQ-033 LSR 0x80000001 by 1 -> 0x40000000, C=1; LSL by 40 -> 0, C=0; ASR 0x80000000 by 40 -> 0xFFFFFFFF, C=1.
REQ-034 Backpressure: hold out_ready low for 5 cycles -> result and out_valid stable and in_ready low; then 3 back-to-back ANDs with out_ready high -> 3 results on consecutive cycles.
REQ-035 Pull rst_n low at cycle 10 of a MUL -> no result emitted, status_out 0000, and in_ready high on the first cycle after release.
